// File: rtl/hazard_pkg.sv
// Shared encodings for the ID-stage hazard controller: FSM states and EX forwarding selects.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LU_WAIT = 2'd1,
    MD_BUSY = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: register addresses and write flags from the stages,
// stall/flush/forward controls back to the pipeline.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2;
  logic [REG_AW-1:0] idex_rd, exmem_rd, memwb_rd;
  logic              id_rs1_used, id_rs2_used;
  logic              idex_mem_read, idex_muldiv;
  logic              exmem_reg_write, memwb_reg_write;
  logic              ex_branch_taken;
  logic              pc_write, ifid_write, idex_bubble, ex_hold;
  logic              ifid_flush, idex_flush, busy;
  logic [1:0]        fwd_a, fwd_b;

  modport master (
    output id_rs1, id_rs2, ex_rs1, ex_rs2, idex_rd, exmem_rd, memwb_rd,
           id_rs1_used, id_rs2_used, idex_mem_read, idex_muldiv,
           exmem_reg_write, memwb_reg_write, ex_branch_taken,
    input  pc_write, ifid_write, idex_bubble, ex_hold, ifid_flush, idex_flush,
           busy, fwd_a, fwd_b
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rs1, ex_rs2, idex_rd, exmem_rd, memwb_rd,
           id_rs1_used, id_rs2_used, idex_mem_read, idex_muldiv,
           exmem_reg_write, memwb_reg_write, ex_branch_taken,
    output pc_write, ifid_write, idex_bubble, ex_hold, ifid_flush, idex_flush,
           busy, fwd_a, fwd_b
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// EX-operand forwarding comparator; the younger EX/MEM result wins over MEM/WB, x0 never forwards.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_write,
  output logic [1:0]        fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_rs)) begin
      fwd = FWD_EX;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_rs)) begin
      fwd = FWD_MEM;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: multi-cycle load-use stalls, MUL/DIV EX hold, branch flush and
// EX forwarding selects. A down-counter keeps the stall alive after the trigger leaves ID/EX.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 5
) (
  input logic            clk,
  input logic            reset_n,
  hazard_ctrl_if.slave   hif
);

  localparam logic [CNT_W-1:0] LS_INIT = CNT_W'((LOAD_STALL > 1) ? LOAD_STALL - 2 : 0);
  localparam logic [CNT_W-1:0] MD_INIT = CNT_W'((MULDIV_LAT > 2) ? MULDIV_LAT - 2 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_hit;
  logic             pc_write, ifid_write, idex_bubble, ex_hold, ifid_flush, idex_flush;
  logic [1:0]       fwd_a_raw, fwd_b_raw;

  assign lu_hit = hif.idex_mem_read && (hif.idex_rd != '0) &&
                  ((hif.id_rs1_used && (hif.id_rs1 == hif.idex_rd)) ||
                   (hif.id_rs2_used && (hif.id_rs2 == hif.idex_rd)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ex_hold     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hif.ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (hif.idex_muldiv) begin
          ex_hold    = 1'b1;
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          if (MULDIV_LAT > 2) begin
            state_d = MD_BUSY;
            cnt_d   = MD_INIT;
          end
        end else if (lu_hit) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (LOAD_STALL > 1) begin
            state_d = LU_WAIT;
            cnt_d   = LS_INIT;
          end
        end
      end
      LU_WAIT: begin
        // A redirect here should be impossible; recover by flushing rather than stalling on.
        if (hif.ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_d    = IDLE;
          cnt_d      = '0;
        end else begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      MD_BUSY: begin
        ex_hold    = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Reset overrides everything so the pipeline sees a frozen front end with NOPs entering EX.
    if (!reset_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      ex_hold     = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
    end
  end

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_rs           (hif.ex_rs1),
    .exmem_rd        (hif.exmem_rd),
    .exmem_reg_write (hif.exmem_reg_write),
    .memwb_rd        (hif.memwb_rd),
    .memwb_reg_write (hif.memwb_reg_write),
    .fwd             (fwd_a_raw)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_rs           (hif.ex_rs2),
    .exmem_rd        (hif.exmem_rd),
    .exmem_reg_write (hif.exmem_reg_write),
    .memwb_rd        (hif.memwb_rd),
    .memwb_reg_write (hif.memwb_reg_write),
    .fwd             (fwd_b_raw)
  );

  assign hif.pc_write    = pc_write;
  assign hif.ifid_write  = ifid_write;
  assign hif.idex_bubble = idex_bubble;
  assign hif.ex_hold     = ex_hold;
  assign hif.ifid_flush  = ifid_flush;
  assign hif.idex_flush  = idex_flush;
  assign hif.busy        = reset_n && (state_q != IDLE);
  assign hif.fwd_a       = reset_n ? fwd_a_raw : FWD_RF;
  assign hif.fwd_b       = reset_n ? fwd_b_raw : FWD_RF;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with LOAD_STALL=1 and one with LOAD_STALL=3,
// both MULDIV_LAT=4, fed identical pipeline inputs.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5)) if1 ();
  hazard_ctrl_if #(.REG_AW(5)) if3 ();

  hazard_ctrl #(.REG_AW(5), .LOAD_STALL(1), .MULDIV_LAT(4), .CNT_W(5)) u1 (
    .clk(clk), .reset_n(reset_n), .hif(if1.slave));
  hazard_ctrl #(.REG_AW(5), .LOAD_STALL(3), .MULDIV_LAT(4), .CNT_W(5)) u3 (
    .clk(clk), .reset_n(reset_n), .hif(if3.slave));

  assign if3.id_rs1          = if1.id_rs1;
  assign if3.id_rs2          = if1.id_rs2;
  assign if3.id_rs1_used     = if1.id_rs1_used;
  assign if3.id_rs2_used     = if1.id_rs2_used;
  assign if3.ex_rs1          = if1.ex_rs1;
  assign if3.ex_rs2          = if1.ex_rs2;
  assign if3.idex_rd         = if1.idex_rd;
  assign if3.idex_mem_read   = if1.idex_mem_read;
  assign if3.idex_muldiv     = if1.idex_muldiv;
  assign if3.exmem_rd        = if1.exmem_rd;
  assign if3.exmem_reg_write = if1.exmem_reg_write;
  assign if3.memwb_rd        = if1.memwb_rd;
  assign if3.memwb_reg_write = if1.memwb_reg_write;
  assign if3.ex_branch_taken = if1.ex_branch_taken;

  task automatic clear_inputs();
    if1.id_rs1 = '0; if1.id_rs2 = '0; if1.id_rs1_used = 0; if1.id_rs2_used = 0;
    if1.ex_rs1 = '0; if1.ex_rs2 = '0; if1.idex_rd = '0; if1.idex_mem_read = 0;
    if1.idex_muldiv = 0; if1.exmem_rd = '0; if1.exmem_reg_write = 0;
    if1.memwb_rd = '0; if1.memwb_reg_write = 0; if1.ex_branch_taken = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    if1.ex_rs1 = 5'd7; if1.exmem_rd = 5'd7; if1.exmem_reg_write = 1;
    #12;
    nvec++; if (if1.pc_write !== 1'b0) begin nerr++; $display("FAIL rst_pc_write got %b want 0", if1.pc_write); end
    nvec++; if (if1.ifid_write !== 1'b0) begin nerr++; $display("FAIL rst_ifid_write got %b want 0", if1.ifid_write); end
    nvec++; if (if1.idex_bubble !== 1'b1) begin nerr++; $display("FAIL rst_bubble got %b want 1", if1.idex_bubble); end
    nvec++; if (if1.busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b want 0", if1.busy); end
    nvec++; if (if1.fwd_a !== 2'b00) begin nerr++; $display("FAIL rst_fwd_a got %b want 00", if1.fwd_a); end
    reset_n = 1'b1;
    clear_inputs();
    tick();
    nvec++; if (if1.pc_write !== 1'b1) begin nerr++; $display("FAIL idle_pc_write got %b want 1", if1.pc_write); end
    nvec++; if (if1.idex_bubble !== 1'b0) begin nerr++; $display("FAIL idle_bubble got %b want 0", if1.idex_bubble); end
  endtask

  task automatic test_load_use();
    if1.idex_mem_read = 1; if1.idex_rd = 5'd5; if1.id_rs1 = 5'd5; if1.id_rs1_used = 1;
    #1;
    nvec++; if (if1.pc_write !== 1'b0) begin nerr++; $display("FAIL lu1_pc_write got %b want 0", if1.pc_write); end
    nvec++; if (if1.ifid_write !== 1'b0) begin nerr++; $display("FAIL lu1_ifid_write got %b want 0", if1.ifid_write); end
    nvec++; if (if1.idex_bubble !== 1'b1) begin nerr++; $display("FAIL lu1_bubble got %b want 1", if1.idex_bubble); end
    nvec++; if (if3.idex_bubble !== 1'b1 || if3.busy !== 1'b0) begin nerr++;
      $display("FAIL lu3_c1 got bubble=%b busy=%b want 1 0", if3.idex_bubble, if3.busy); end
    tick();
    clear_inputs();
    #1;
    nvec++; if (if1.pc_write !== 1'b1 || if1.idex_bubble !== 1'b0) begin nerr++;
      $display("FAIL lu1_release got pc=%b bubble=%b want 1 0", if1.pc_write, if1.idex_bubble); end
    nvec++; if (if3.idex_bubble !== 1'b1 || if3.busy !== 1'b1 || if3.pc_write !== 1'b0) begin nerr++;
      $display("FAIL lu3_c2 got bubble=%b busy=%b pc=%b want 1 1 0", if3.idex_bubble, if3.busy, if3.pc_write); end
    tick();
    nvec++; if (if3.idex_bubble !== 1'b1 || if3.busy !== 1'b1) begin nerr++;
      $display("FAIL lu3_c3 got bubble=%b busy=%b want 1 1", if3.idex_bubble, if3.busy); end
    tick();
    nvec++; if (if3.idex_bubble !== 1'b0 || if3.busy !== 1'b0 || if3.pc_write !== 1'b1) begin nerr++;
      $display("FAIL lu3_c4 got bubble=%b busy=%b pc=%b want 0 0 1", if3.idex_bubble, if3.busy, if3.pc_write); end
  endtask

  task automatic test_x0_and_rs2();
    clear_inputs();
    if1.idex_mem_read = 1; if1.idex_rd = 5'd0; if1.id_rs1 = 5'd0; if1.id_rs1_used = 1;
    if1.ex_rs1 = 5'd0; if1.exmem_rd = 5'd0; if1.exmem_reg_write = 1;
    #1;
    nvec++; if (if1.pc_write !== 1'b1 || if1.idex_bubble !== 1'b0) begin nerr++;
      $display("FAIL x0_stall got pc=%b bubble=%b want 1 0", if1.pc_write, if1.idex_bubble); end
    nvec++; if (if1.fwd_a !== 2'b00) begin nerr++; $display("FAIL x0_fwd_a got %b want 00", if1.fwd_a); end
    clear_inputs();
    if1.idex_mem_read = 1; if1.idex_rd = 5'd9; if1.id_rs2 = 5'd9; if1.id_rs2_used = 0;
    #1;
    nvec++; if (if1.idex_bubble !== 1'b0) begin nerr++; $display("FAIL rs2_unused got %b want 0", if1.idex_bubble); end
    if1.id_rs2_used = 1;
    #1;
    nvec++; if (if1.idex_bubble !== 1'b1 || if1.pc_write !== 1'b0) begin nerr++;
      $display("FAIL rs2_hit got bubble=%b pc=%b want 1 0", if1.idex_bubble, if1.pc_write); end
    tick();
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_forward();
    clear_inputs();
    if1.ex_rs1 = 5'd7; if1.exmem_rd = 5'd7; if1.exmem_reg_write = 1;
    if1.memwb_rd = 5'd7; if1.memwb_reg_write = 1;
    #1;
    nvec++; if (if1.fwd_a !== 2'b10) begin nerr++; $display("FAIL fwd_a_ex got %b want 10", if1.fwd_a); end
    if1.exmem_reg_write = 0;
    #1;
    nvec++; if (if1.fwd_a !== 2'b01) begin nerr++; $display("FAIL fwd_a_mem got %b want 01", if1.fwd_a); end
    if1.memwb_reg_write = 0;
    #1;
    nvec++; if (if1.fwd_a !== 2'b00) begin nerr++; $display("FAIL fwd_a_rf got %b want 00", if1.fwd_a); end
    if1.ex_rs2 = 5'd3; if1.memwb_rd = 5'd3; if1.memwb_reg_write = 1;
    if1.exmem_rd = 5'd4; if1.exmem_reg_write = 1;
    #1;
    nvec++; if (if1.fwd_b !== 2'b01) begin nerr++; $display("FAIL fwd_b_mem got %b want 01", if1.fwd_b); end
    if1.exmem_rd = 5'd3;
    #1;
    nvec++; if (if1.fwd_b !== 2'b10) begin nerr++; $display("FAIL fwd_b_ex got %b want 10", if1.fwd_b); end
    clear_inputs();
  endtask

  task automatic test_muldiv();
    clear_inputs();
    if1.idex_muldiv = 1;
    #1;
    nvec++; if (if1.ex_hold !== 1'b1 || if1.pc_write !== 1'b0 || if1.busy !== 1'b0) begin nerr++;
      $display("FAIL md_c1 got hold=%b pc=%b busy=%b want 1 0 0", if1.ex_hold, if1.pc_write, if1.busy); end
    tick();
    if1.idex_muldiv = 0;
    #1;
    nvec++; if (if1.ex_hold !== 1'b1 || if1.busy !== 1'b1) begin nerr++;
      $display("FAIL md_c2 got hold=%b busy=%b want 1 1", if1.ex_hold, if1.busy); end
    tick();
    if1.ex_branch_taken = 1;
    #1;
    nvec++; if (if1.ex_hold !== 1'b1 || if1.ifid_flush !== 1'b0 || if1.idex_flush !== 1'b0) begin nerr++;
      $display("FAIL md_c3 got hold=%b flush=%b%b want 1 00", if1.ex_hold, if1.ifid_flush, if1.idex_flush); end
    tick();
    if1.ex_branch_taken = 0;
    #1;
    nvec++; if (if1.ex_hold !== 1'b1 || if1.ifid_write !== 1'b0) begin nerr++;
      $display("FAIL md_c4 got hold=%b ifid_write=%b want 1 0", if1.ex_hold, if1.ifid_write); end
    tick();
    nvec++; if (if1.ex_hold !== 1'b0 || if1.busy !== 1'b0 || if1.pc_write !== 1'b1) begin nerr++;
      $display("FAIL md_c5 got hold=%b busy=%b pc=%b want 0 0 1", if1.ex_hold, if1.busy, if1.pc_write); end
  endtask

  task automatic test_branch_lu();
    clear_inputs();
    if1.idex_mem_read = 1; if1.idex_rd = 5'd5; if1.id_rs1 = 5'd5; if1.id_rs1_used = 1;
    if1.ex_branch_taken = 1;
    #1;
    nvec++; if (if3.ifid_flush !== 1'b1 || if3.idex_flush !== 1'b1) begin nerr++;
      $display("FAIL br_flush got %b%b want 11", if3.ifid_flush, if3.idex_flush); end
    nvec++; if (if3.idex_bubble !== 1'b0 || if3.pc_write !== 1'b1) begin nerr++;
      $display("FAIL br_nostall got bubble=%b pc=%b want 0 1", if3.idex_bubble, if3.pc_write); end
    tick();
    clear_inputs();
    #1;
    nvec++; if (if3.busy !== 1'b0 || if3.ifid_flush !== 1'b0) begin nerr++;
      $display("FAIL br_after got busy=%b flush=%b want 0 0", if3.busy, if3.ifid_flush); end
  endtask

  task automatic test_reset_in_luwait();
    clear_inputs();
    if1.idex_mem_read = 1; if1.idex_rd = 5'd6; if1.id_rs2 = 5'd6; if1.id_rs2_used = 1;
    tick();
    clear_inputs();
    if1.ex_rs1 = 5'd2; if1.exmem_rd = 5'd2; if1.exmem_reg_write = 1;
    #1;
    nvec++; if (if3.busy !== 1'b1) begin nerr++; $display("FAIL rw_busy got %b want 1", if3.busy); end
    reset_n = 1'b0;
    #1;
    nvec++; if (if3.busy !== 1'b0 || if3.pc_write !== 1'b0 || if3.idex_bubble !== 1'b1 || if3.fwd_a !== 2'b00) begin nerr++;
      $display("FAIL rw_rst got busy=%b pc=%b bubble=%b fwd_a=%b want 0 0 1 00", if3.busy, if3.pc_write, if3.idex_bubble, if3.fwd_a); end
    tick();
    reset_n = 1'b1;
    #1;
    nvec++; if (if3.busy !== 1'b0 || if3.pc_write !== 1'b1 || if3.idex_bubble !== 1'b0 || if3.fwd_a !== 2'b10) begin nerr++;
      $display("FAIL rw_release got busy=%b pc=%b bubble=%b fwd_a=%b want 0 1 0 10", if3.busy, if3.pc_write, if3.idex_bubble, if3.fwd_a); end
    tick();
    nvec++; if (if3.busy !== 1'b0 || if3.idex_bubble !== 1'b0) begin nerr++;
      $display("FAIL rw_idle got busy=%b bubble=%b want 0 0", if3.busy, if3.idex_bubble); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_and_rs2();
    test_forward();
    test_muldiv();
    test_branch_lu();
    test_reset_in_luwait();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
